// File: rtl/calc_controller.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : calc_controller                                                 |
// | Brief    : Single-digit calculator. Executes + - * (and / when CALC_DIV_EN |
// |            is defined), converts the signed result to ASCII and streams    |
// |            it, followed by CR LF, to a UART transmitter.                   |
// | Options  : CALC_DIV_EN - enables the '/' operator and the DIV state.      |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module calc_controller (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] operand1,
  input  logic [7:0] operand2,
  input  logic [7:0] operator,
  input  logic       cmd_valid,
  input  logic       tx_busy,
  output logic [7:0] tx_data,
  output logic       tx_start,
  output logic       busy,
  output logic [7:0] result,
  output logic [3:0] drop_cnt,
  output logic [2:0] state_debug
);

  localparam logic [7:0] c_OP_ADD = 8'h2B;
  localparam logic [7:0] c_OP_SUB = 8'h2D;
  localparam logic [7:0] c_OP_MUL = 8'h2A;
  localparam logic [7:0] c_OP_DIV = 8'h2F;
  localparam logic [7:0] c_CH_MINUS = 8'h2D;
  localparam logic [7:0] c_CH_ZERO  = 8'h30;
  localparam logic [7:0] c_CH_CR    = 8'h0D;
  localparam logic [7:0] c_CH_LF    = 8'h0A;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    EXEC     = 3'd1,
`ifdef CALC_DIV_EN
    DIV      = 3'd2,
`endif
    CONV     = 3'd3,
    SEND     = 3'd4,
    WAIT_ACK = 3'd5,
    WAIT_TX  = 3'd6
  } state_t;

  state_t     r_state, w_next;
  logic [7:0] r_op1, r_op2, r_opc;
  logic [7:0] r_mag;        // magnitude being digitised; remainder while dividing
  logic [7:0] r_tens;       // tens count in CONV; quotient while dividing
  logic       r_err;
  logic [7:0] r_err_char;
  logic [7:0] r_buf [0:4];
  logic [2:0] r_len, r_idx;

  logic [7:0] w_exec_val, w_exec_abs, w_err_char;
  logic       w_exec_ok, w_div_go, w_neg, w_has_tens;
  logic [2:0] w_pos;
  logic [7:0] w_build [0:4];

`ifdef CALC_DIV_EN
  // A zero divisor skips the iterations and reports 'E' straight away.
  assign w_div_go   = (r_opc == c_OP_DIV) && (r_op2 != 8'h00);
  assign w_err_char = (r_opc == c_OP_DIV) ? 8'h45 : 8'h3F;
`else
  // Division is not built: '/' falls through as an unknown operator.
  assign w_div_go   = 1'b0;
  assign w_err_char = 8'h3F;
`endif

  // Arithmetic for the single-cycle operators.
  always_comb begin
    w_exec_val = 8'h00;
    w_exec_ok  = 1'b1;
    case (r_opc)
      c_OP_ADD: w_exec_val = r_op1 + r_op2;
      c_OP_SUB: w_exec_val = r_op1 - r_op2;
      c_OP_MUL: w_exec_val = r_op1 * r_op2;
      default:  w_exec_ok  = 1'b0;
    endcase
  end

  assign w_exec_abs = w_exec_val[7] ? (8'h00 - w_exec_val) : w_exec_val;
  assign w_neg      = !r_err && result[7];
  assign w_has_tens = !r_err && (r_tens != 8'h00);
  assign w_pos      = {2'b00, w_neg} + {2'b00, w_has_tens};

  // Character buffer image: [sign] [tens] ones CR LF, packed from entry 0.
  always_comb begin
    w_build = '{default: 8'h00};
    if (w_neg)      w_build[0] = c_CH_MINUS;
    if (w_has_tens) w_build[{2'b00, w_neg}] = c_CH_ZERO + r_tens;
    w_build[w_pos]        = r_err ? r_err_char : (c_CH_ZERO + r_mag);
    w_build[w_pos + 3'd1] = c_CH_CR;
    w_build[w_pos + 3'd2] = c_CH_LF;
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  // Next-state decode and state-derived outputs.
  always_comb begin
    w_next      = r_state;
    busy        = (r_state != IDLE);
    state_debug = r_state;
    case (r_state)
      IDLE:     if (cmd_valid) w_next = EXEC;
      EXEC: begin
        w_next = CONV;
`ifdef CALC_DIV_EN
        if (w_div_go) w_next = DIV;
`endif
      end
`ifdef CALC_DIV_EN
      DIV:      if (r_mag < r_op2) w_next = CONV;
`endif
      CONV:     if (r_err || (r_mag < 8'd10)) w_next = SEND;
      SEND:     if (!tx_busy) w_next = WAIT_ACK;
      WAIT_ACK: w_next = WAIT_TX;
      WAIT_TX:  if (!tx_busy) w_next = (r_idx < r_len) ? SEND : IDLE;
      default:  w_next = IDLE;
    endcase
  end

  // Datapath: command capture, arithmetic, digit conversion and transmit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_op1      <= 8'h00;
      r_op2      <= 8'h00;
      r_opc      <= 8'h00;
      r_mag      <= 8'h00;
      r_tens     <= 8'h00;
      r_err      <= 1'b0;
      r_err_char <= 8'h00;
      r_buf      <= '{default: 8'h00};
      r_len      <= 3'd0;
      r_idx      <= 3'd0;
      tx_data    <= 8'h00;
      tx_start   <= 1'b0;
      result     <= 8'h00;
      drop_cnt   <= 4'd0;
    end else begin
      tx_start <= 1'b0;
      if (cmd_valid && (r_state != IDLE) && (drop_cnt != 4'hF))
        drop_cnt <= drop_cnt + 4'd1;
      case (r_state)
        IDLE: begin
          if (cmd_valid) begin
            r_op1 <= operand1;
            r_op2 <= operand2;
            r_opc <= operator;
          end
        end
        EXEC: begin
          r_tens <= 8'h00;
          r_err  <= 1'b0;
          if (w_div_go) begin
            r_mag <= r_op1;
          end else if (w_exec_ok) begin
            result <= w_exec_val;
            r_mag  <= w_exec_abs;
          end else begin
            result     <= 8'h00;
            r_mag      <= 8'h00;
            r_err      <= 1'b1;
            r_err_char <= w_err_char;
          end
        end
`ifdef CALC_DIV_EN
        DIV: begin
          if (r_mag >= r_op2) begin
            r_mag  <= r_mag - r_op2;
            r_tens <= r_tens + 8'd1;
          end else begin
            result <= r_tens;
            r_mag  <= r_tens;
            r_tens <= 8'h00;
          end
        end
`endif
        CONV: begin
          if (!r_err && (r_mag >= 8'd10)) begin
            r_mag  <= r_mag - 8'd10;
            r_tens <= r_tens + 8'd1;
          end else begin
            r_buf <= w_build;
            r_len <= w_pos + 3'd3;
            r_idx <= 3'd0;
          end
        end
        SEND: begin
          if (!tx_busy) begin
            tx_data  <= r_buf[r_idx];
            tx_start <= 1'b1;
            r_idx    <= r_idx + 3'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_calc_controller.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_calc_controller                                              |
// | Brief    : Directed self-checking bench for calc_controller with a small  |
// |            UART responder that captures every transmitted character.      |
// | Options  : CALC_DIV_EN - selects the division expectations.               |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
`timescale 1ns/1ps
module tb_calc_controller;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] operand1 = 8'h00, operand2 = 8'h00, operator = 8'h00;
  logic       cmd_valid = 1'b0;
  logic       tx_busy = 1'b0;
  logic [7:0] tx_data;
  logic       tx_start;
  logic       busy;
  logic [7:0] result;
  logic [3:0] drop_cnt;
  logic [2:0] state_debug;

  int         checks = 0;
  int         failures = 0;
  logic [7:0] q[$];
  int         n_start = 0;
  int         bcnt = 0;
  logic       hold_busy = 1'b0;
  int         n0;

  always #5 clk = ~clk;

  calc_controller dut (
    .clk(clk), .rst_n(rst_n), .operand1(operand1), .operand2(operand2),
    .operator(operator), .cmd_valid(cmd_valid), .tx_busy(tx_busy),
    .tx_data(tx_data), .tx_start(tx_start), .busy(busy), .result(result),
    .drop_cnt(drop_cnt), .state_debug(state_debug)
  );

  // UART responder: capture each request, stay busy for three cycles.
  always @(negedge clk) begin
    if (tx_start === 1'b1) begin
      q.push_back(tx_data);
      n_start++;
      bcnt = 3;
    end else if (bcnt > 0) begin
      bcnt--;
    end
    tx_busy = hold_busy || (bcnt != 0);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic [7:0] a, input logic [7:0] op, input logic [7:0] b);
    q.delete();
    operand1 = a; operator = op; operand2 = b; cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int k = 0;
    while (busy !== 1'b0 && k < 400) begin @(negedge clk); k++; end
    chk({tag, "_idle"}, {31'h0, busy}, 32'h0);
  endtask

  task automatic wait_state(input logic [2:0] s, input string tag);
    int k = 0;
    while (state_debug !== s && k < 100) begin @(negedge clk); k++; end
    chk(tag, {29'h0, state_debug}, {29'h0, s});
  endtask

  task automatic check_seq(input string tag, input int n, input logic [7:0] e0,
                           input logic [7:0] e1, input logic [7:0] e2, input logic [7:0] e3);
    logic [7:0] e[4];
    logic [7:0] g;
    e = '{e0, e1, e2, e3};
    chk({tag, "_len"}, q.size(), n);
    for (int i = 0; i < n; i++) begin
      g = 8'hxx;
      if (i < q.size()) g = q[i];
      chk($sformatf("%s_ch%0d", tag, i), {24'h0, g}, {24'h0, e[i]});
    end
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_tx_start"}, {31'h0, tx_start}, 32'h0);
    chk({tag, "_tx_data"},  {24'h0, tx_data}, 32'h0);
    chk({tag, "_busy"},     {31'h0, busy}, 32'h0);
    chk({tag, "_result"},   {24'h0, result}, 32'h0);
    chk({tag, "_drop"},     {28'h0, drop_cnt}, 32'h0);
    chk({tag, "_state"},    {29'h0, state_debug}, 32'h0);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check_reset("rst");
    rst_n = 1'b1;
    @(negedge clk);

    // 3 + 4 with EXEC/CONV timing
    issue(8'd3, 8'h2B, 8'd4);
    chk("exec_state", {29'h0, state_debug}, 32'd1);
    chk("exec_busy", {31'h0, busy}, 32'd1);
    @(negedge clk);
    chk("conv_at_2", {29'h0, state_debug}, 32'd3);
    wait_idle("add");
    check_seq("add", 3, 8'h37, 8'h0D, 8'h0A, 8'h00);
    chk("add_res", {24'h0, result}, 32'h07);

    // unknown operator, issued in the IDLE cycle busy falls
    issue(8'd5, 8'h25, 8'd3);
    wait_idle("unk");
    check_seq("unk", 3, 8'h3F, 8'h0D, 8'h0A, 8'h00);
    chk("unk_res", {24'h0, result}, 32'h00);

    issue(8'd2, 8'h2D, 8'd7);
    wait_idle("sub");
    check_seq("sub", 4, 8'h2D, 8'h35, 8'h0D, 8'h0A);
    chk("sub_res", {24'h0, result}, 32'hFB);

    // 9 * 9 with a rejected command during SEND
    issue(8'd9, 8'h2A, 8'd9);
    wait_state(3'd4, "mul_send");
    operand1 = 8'd1; operator = 8'h2B; operand2 = 8'd1; cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    wait_idle("mul");
    check_seq("mul", 4, 8'h38, 8'h31, 8'h0D, 8'h0A);
    chk("mul_res", {24'h0, result}, 32'h51);
    chk("drop_one", {28'h0, drop_cnt}, 32'd1);

    issue(8'd0, 8'h2A, 8'd0);
    wait_idle("zero");
    check_seq("zero", 3, 8'h30, 8'h0D, 8'h0A, 8'h00);
    chk("zero_res", {24'h0, result}, 32'h00);

    issue(8'd9, 8'h2F, 8'd2);
    wait_idle("div");
`ifdef CALC_DIV_EN
    check_seq("div", 3, 8'h34, 8'h0D, 8'h0A, 8'h00);
    chk("div_res", {24'h0, result}, 32'h04);
    issue(8'd8, 8'h2F, 8'd0);
    wait_idle("div0");
    check_seq("div0", 3, 8'h45, 8'h0D, 8'h0A, 8'h00);
    chk("div0_res", {24'h0, result}, 32'h00);
`else
    check_seq("div", 3, 8'h3F, 8'h0D, 8'h0A, 8'h00);
    chk("div_res", {24'h0, result}, 32'h00);
`endif

    // transmitter stuck busy: no requests, drops saturate
    hold_busy = 1'b1;
    @(negedge clk);
    issue(8'd3, 8'h2B, 8'd4);
    wait_state(3'd4, "stuck_send");
    n0 = n_start;
    for (int i = 0; i < 14; i++) begin
      cmd_valid = 1'b1; @(negedge clk);
      cmd_valid = 1'b0; @(negedge clk);
    end
    chk("drop_15", {28'h0, drop_cnt}, 32'd15);
    for (int i = 0; i < 2; i++) begin
      cmd_valid = 1'b1; @(negedge clk);
      cmd_valid = 1'b0; @(negedge clk);
    end
    chk("drop_sat", {28'h0, drop_cnt}, 32'd15);
    repeat (68) @(negedge clk);
    chk("stuck_no_tx", n_start, n0);
    chk("stuck_state", {29'h0, state_debug}, 32'd4);

    // reset while in SEND
    rst_n = 1'b0;
    #1;
    check_reset("midrst");
    @(negedge clk);
    rst_n = 1'b1;
    hold_busy = 1'b0;
    q.delete();
    repeat (50) @(negedge clk);
    chk("post_rst_no_tx", n_start, n0);
    chk("post_rst_state", {29'h0, state_debug}, 32'd0);

    issue(8'd6, 8'h2B, 8'd3);
    wait_idle("final");
    check_seq("final", 3, 8'h39, 8'h0D, 8'h0A, 8'h00);
    chk("final_res", {24'h0, result}, 32'h09);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
